// File: rtl/input_unit.sv
// Router input port front end: flit FIFO, route lookup handshake, per-packet
// outport latch, switch/crossbar streaming, drop path and credit return.
module input_unit #(
    parameter logic [2:0]  PORT   = 3'd1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              credit_out,
    output logic [2:0]        rcu_inport,
    output logic [5:0]        rcu_dest,
    input  logic [2:0]        rcu_outport,
    output logic              sa_req,
    output logic [2:0]        sa_outport,
    input  logic              sa_grant,
    output logic              xb_valid,
    output logic [FLIT_W-1:0] xb_flit,
    output logic              drop_pulse,
    output logic              err_overflow,
    output logic              err_protocol
);

    localparam int unsigned POS_W = 6;
    localparam logic [2:0]  P_LOCAL = 3'd0;
    localparam logic [2:0]  P_DROP  = 3'd7;
    localparam logic [1:0]  T_HEAD  = 2'd0;
    localparam logic [1:0]  T_TAIL  = 2'd2;
    localparam logic [1:0]  T_HT    = 2'd3;

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE, DRAIN} state_t;

    state_t state, state_next, state_eff;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty, full, push, pop;
    logic [FLIT_W-1:0] head;
    logic [1:0]        head_type;
    logic              head_is_start, head_is_end;
    logic              route, bad_head;

    always_comb begin
        empty         = (count == '0);
        full          = (count == FULL_CNT);
        head          = mem[rd_ptr];
        head_type     = head[FLIT_W-1 -: 2];
        head_is_start = (head_type == T_HEAD) || (head_type == T_HT);
        head_is_end   = (head_type == T_TAIL) || (head_type == T_HT);
        push          = in_valid && (!full || pop);
        rcu_inport    = PORT;
        rcu_dest      = head[POS_W-1:0];
        xb_flit       = head;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A start flit at the head of an idle unit is routed in the cycle it
    // becomes visible, so ROUTE is entered combinationally, never registered.
    always_comb begin
        state_eff = state;
        if (state == IDLE && !empty && head_is_start) state_eff = ROUTE;
        route      = 1'b0;
        bad_head   = 1'b0;
        sa_req     = 1'b0;
        xb_valid   = 1'b0;
        drop_pulse = 1'b0;
        pop        = 1'b0;
        case (state_eff)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    drop_pulse = 1'b1;
                    bad_head   = 1'b1;
                end
            end
            ROUTE: route = 1'b1;
            ACTIVE: begin
                sa_req   = !empty;
                pop      = sa_req && sa_grant;
                xb_valid = pop;
            end
            DRAIN: begin
                pop        = !empty;
                drop_pulse = pop;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_eff;
        case (state_eff)
            ROUTE:         state_next = (rcu_outport == P_DROP) ? DRAIN : ACTIVE;
            ACTIVE, DRAIN: if (pop && head_is_end) state_next = IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_out   <= 1'b0;
            sa_outport   <= P_LOCAL;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            credit_out <= pop;
            if (route) sa_outport <= rcu_outport;
            if (in_valid && full && !pop) err_overflow <= 1'b1;
            if (bad_head) err_protocol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_unit.sv
// Bench for input_unit: packet-level queue model checked every cycle, plus
// directed scenarios with literal expectations on latency, ordering and errors.
module tb_input_unit;

    localparam int unsigned FW = 32;
    localparam logic [2:0] LOCAL = 3'd0, EAST = 3'd1, WEST = 3'd2, NORTH = 3'd3,
                           SOUTH = 3'd4, DROP = 3'd7;
    localparam logic [1:0] T_HEAD = 2'd0, T_BODY = 2'd1, T_TAIL = 2'd2, T_HT = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic [2:0]    rcu_outport = LOCAL;
    logic          sa_grant = 1'b0;
    logic          credit_out, sa_req, xb_valid, drop_pulse, err_overflow, err_protocol;
    logic [2:0]    rcu_inport, sa_outport;
    logic [5:0]    rcu_dest;
    logic [FW-1:0] xb_flit;

    input_unit #(.PORT(EAST), .DEPTH(4), .FLIT_W(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
        .credit_out(credit_out), .rcu_inport(rcu_inport), .rcu_dest(rcu_dest),
        .rcu_outport(rcu_outport), .sa_req(sa_req), .sa_outport(sa_outport),
        .sa_grant(sa_grant), .xb_valid(xb_valid), .xb_flit(xb_flit),
        .drop_pulse(drop_pulse), .err_overflow(err_overflow), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [FW-1:0] mk(logic [1:0] t, logic [29:0] p);
        return {t, p};
    endfunction

    function automatic bit is_start(logic [FW-1:0] f);
        return (f[31:30] == T_HEAD) || (f[31:30] == T_HT);
    endfunction

    function automatic bit is_end(logic [FW-1:0] f);
        return (f[31:30] == T_TAIL) || (f[31:30] == T_HT);
    endfunction

    // Model: queued flits plus what the unit is doing with the current packet
    // (0 waiting for a head, 1 forwarding, 2 discarding).
    logic [FW-1:0] mq[$];
    int            m_mode   = 0;
    logic [2:0]    m_port   = LOCAL;
    logic          m_credit = 1'b0;
    logic          m_ovf    = 1'b0;
    logic          m_proto  = 1'b0;

    function automatic bit m_pops();
        if (mq.size() == 0) return 1'b0;
        case (m_mode)
            0:       return !is_start(mq[0]);
            1:       return sa_grant;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        bit            p;
        logic [FW-1:0] f;
        if (rst) begin
            mq.delete();
            m_mode   = 0;
            m_port   = LOCAL;
            m_credit = 1'b0;
            m_ovf    = 1'b0;
            m_proto  = 1'b0;
        end else begin
            p        = m_pops();
            m_credit = p;
            if (m_mode == 0 && mq.size() > 0 && is_start(mq[0])) begin
                m_port = rcu_outport;
                m_mode = (rcu_outport == DROP) ? 2 : 1;
            end else if (p) begin
                f = mq.pop_front();
                if (m_mode == 0) m_proto = 1'b1;
                else if (is_end(f)) m_mode = 0;
            end
            if (in_valid) begin
                if (mq.size() < 4) mq.push_back(in_flit);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic e_req, e_xb, e_drop;
        e_req  = 1'b0;
        e_xb   = 1'b0;
        e_drop = 1'b0;
        if (!rst && mq.size() > 0) begin
            case (m_mode)
                0: e_drop = !is_start(mq[0]);
                1: begin e_req = 1'b1; e_xb = sa_grant; end
                default: e_drop = 1'b1;
            endcase
            chk("rcu_dest", rcu_dest, mq[0][5:0]);
            if (e_xb) chk("xb_flit", xb_flit, mq[0]);
        end
        chk("sa_req", sa_req, e_req);
        chk("xb_valid", xb_valid, e_xb);
        chk("drop_pulse", drop_pulse, e_drop);
        chk("credit_out", credit_out, m_credit);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_protocol", err_protocol, m_proto);
        chk("sa_outport", sa_outport, m_port);
        chk("rcu_inport", rcu_inport, EAST);
    end

    logic [FW-1:0] got[$];
    int            n_cr, n_dr;

    task automatic cyc(input logic v, input logic [FW-1:0] f, input logic g);
        @(posedge clk);
        #1;
        in_valid = v;
        in_flit  = f;
        sa_grant = g;
        @(negedge clk);
    endtask

    task automatic collect();
        if (xb_valid) got.push_back(xb_flit);
        if (credit_out) n_cr++;
        if (drop_pulse) n_dr++;
    endtask

    task automatic clear_obs();
        got.delete();
        n_cr = 0;
        n_dr = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] h, b1, b2, t, f5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_credit", credit_out, 0);
        chk("reset_outport", sa_outport, LOCAL);
        chk("reset_errs", {err_overflow, err_protocol}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single HEADTAIL to LOCAL, minimum latency
        rcu_outport = LOCAL;
        cyc(1, mk(T_HT, 30'h15), 0);
        chk("t1_req_t0", sa_req, 0);
        cyc(0, '0, 0);
        chk("t1_route_dest", rcu_dest, 6'h15);
        chk("t1_route_req", sa_req, 0);
        cyc(0, '0, 1);
        chk("t1_req_t2", sa_req, 1);
        chk("t1_xb_t2", xb_valid, 1);
        chk("t1_flit", xb_flit, 32'hC000_0015);
        cyc(0, '0, 0);
        chk("t1_credit_t3", credit_out, 1);
        chk("t1_idle_req", sa_req, 0);

        // Four-flit packet to EAST, grant withheld until full, then grant + push
        rcu_outport = EAST;
        h  = mk(T_HEAD, 30'h21);
        b1 = mk(T_BODY, 30'h111);
        b2 = mk(T_BODY, 30'h222);
        t  = mk(T_TAIL, 30'h333);
        f5 = mk(T_HT, 30'h2A);
        cyc(1, h, 0);
        cyc(1, b1, 0);
        cyc(1, b2, 0);
        cyc(1, t, 0);
        cyc(0, '0, 0);
        chk("t2_full_req", sa_req, 1);
        chk("t2_full_port", sa_outport, EAST);
        clear_obs();
        cyc(1, f5, 1);
        collect();
        for (int unsigned i = 0; i < 9; i++) begin
            cyc(0, '0, 1);
            if (i == 0) chk("t2_no_ovf", err_overflow, 0);
            if (xb_valid) chk("t2_port", sa_outport, EAST);
            collect();
        end
        chk("t2_xb_count", got.size(), 5);
        if (got.size() == 5) begin
            chk("t2_ord0", got[0], h);
            chk("t2_ord1", got[1], b1);
            chk("t2_ord2", got[2], b2);
            chk("t2_ord3", got[3], t);
            chk("t2_ord4", got[4], f5);
        end
        chk("t2_credits", n_cr, 5);

        // Three-flit packet routed to DROP
        rcu_outport = DROP;
        clear_obs();
        cyc(1, mk(T_HEAD, 30'h3), 0);
        collect();
        cyc(1, mk(T_BODY, 30'h4), 0);
        collect();
        cyc(1, mk(T_TAIL, 30'h5), 0);
        collect();
        for (int unsigned i = 0; i < 6; i++) begin
            cyc(0, '0, 0);
            collect();
        end
        chk("t3_drops", n_dr, 3);
        chk("t3_credits", n_cr, 3);
        chk("t3_xb", got.size(), 0);
        rcu_outport = LOCAL;
        clear_obs();
        cyc(1, mk(T_HT, 30'h6), 0);
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(0, '0, 1);
            collect();
        end
        chk("t3_next_xb", got.size(), 1);

        // Five flits into a four-deep FIFO with no grant
        rcu_outport = NORTH;
        clear_obs();
        h = mk(T_HEAD, 30'h31);
        t = mk(T_TAIL, 30'h34);
        cyc(1, h, 0);
        cyc(1, mk(T_BODY, 30'h32), 0);
        cyc(1, mk(T_BODY, 30'h33), 0);
        cyc(1, t, 0);
        cyc(1, mk(T_HT, 30'h35), 0);
        chk("t4_no_ovf_yet", err_overflow, 0);
        cyc(0, '0, 0);
        chk("t4_ovf", err_overflow, 1);
        for (int unsigned i = 0; i < 8; i++) begin
            cyc(0, '0, 1);
            collect();
        end
        chk("t4_xb_count", got.size(), 4);
        if (got.size() == 4) chk("t4_last", got[3], t);
        chk("t4_ovf_sticky", err_overflow, 1);

        // BODY flit first after reset
        pulse_reset();
        cyc(1, mk(T_BODY, 30'h77), 0);
        cyc(0, '0, 0);
        chk("t5_drop", drop_pulse, 1);
        chk("t5_proto_pre", err_protocol, 0);
        cyc(0, '0, 0);
        chk("t5_proto", err_protocol, 1);
        chk("t5_credit", credit_out, 1);
        rcu_outport = WEST;
        cyc(1, mk(T_HT, 30'h9), 0);
        cyc(0, '0, 0);
        cyc(0, '0, 1);
        chk("t5_next_xb", xb_valid, 1);
        chk("t5_next_port", sa_outport, WEST);

        // Reset in the middle of an active packet
        rcu_outport = SOUTH;
        cyc(1, mk(T_HEAD, 30'h41), 0);
        cyc(1, mk(T_BODY, 30'h42), 0);
        cyc(1, mk(T_BODY, 30'h43), 0);
        cyc(1, mk(T_TAIL, 30'h44), 0);
        cyc(0, '0, 1);
        cyc(0, '0, 1);
        chk("t6_second_xb", xb_valid, 1);
        @(posedge clk);
        #1;
        sa_grant = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_credit", credit_out, 0);
        chk("t6_rst_req", sa_req, 0);
        chk("t6_rst_port", sa_outport, LOCAL);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(0, '0, 1);
            collect();
        end
        chk("t6_no_credits", n_cr, 0);
        chk("t6_no_xb", got.size(), 0);
        rcu_outport = LOCAL;
        clear_obs();
        cyc(1, mk(T_HT, 30'h12), 0);
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(0, '0, 1);
            collect();
        end
        chk("t6_new_xb", got.size(), 1);
        chk("t6_new_credit", n_cr, 1);

        cyc(0, '0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
